// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC,
// NOP encoding, reset polarity and the fetch-buffer entry layout.
package inst_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // Reset is active-high and sampled on clk
    localparam logic RST_ACTIVE = 1'b1;

    // One fetch-buffer slot: address, returned word, and its tags
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
        logic            killed;
    } fetchEntry_t;

    // Sequential next PC, wrapping modulo 2^32
    function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Circular tagged fetch buffer. Entries are allocated in request order,
// filled in response order (oldest unfilled first) and popped from the head.
// A kill marks every entry as squashed, optionally sparing the head slot.
// Killed entries still wait for their response so later responses land in
// the right slot.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] allocPc_i,
    input  logic            allocKilled_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fillData_i,
    input  logic            pop_i,
    input  logic            kill_i,
    input  logic            keepHead_i,
    output logic [CW-1:0]   count_o,
    output logic            headReady_o,
    output logic            headKilled_o,
    output logic [XLEN-1:0] headPc_o,
    output logic [XLEN-1:0] headInst_o
);

    localparam int PW = $clog2(DEPTH);

    fetchEntry_t     entries_q [DEPTH];
    logic [PW-1:0]   headPtr_q;
    logic [PW-1:0]   tailPtr_q;
    logic [PW-1:0]   fillPtr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   pending_q;
    logic            fillHit;
    logic            headFillNow;

    // A response only counts when some allocated entry is still waiting for one
    assign fillHit     = fill_i && (pending_q != '0);
    assign headFillNow = fillHit && (fillPtr_q == headPtr_q);

    // Head view, with the arriving word bypassed so it is usable the same cycle
    assign headReady_o  = (count_q != '0) && (entries_q[headPtr_q].filled || headFillNow);
    assign headKilled_o = entries_q[headPtr_q].killed;
    assign headPc_o     = entries_q[headPtr_q].pc;
    assign headInst_o   = entries_q[headPtr_q].filled ? entries_q[headPtr_q].inst : fillData_i;
    assign count_o      = count_q;

    // Pointer, occupancy and per-entry tag updates; allocation overrides a kill
    // on the tail slot so a same-cycle grant takes its own killed flag
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            fillPtr_q <= '0;
            count_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].filled <= 1'b0;
                entries_q[i].killed <= 1'b0;
            end
        end else begin
            if (kill_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!(keepHead_i && (PW'(i) == headPtr_q))) begin
                        entries_q[i].killed <= 1'b1;
                    end
                end
            end
            if (fillHit) begin
                entries_q[fillPtr_q].inst   <= fillData_i;
                entries_q[fillPtr_q].filled <= 1'b1;
                fillPtr_q <= fillPtr_q + 1'b1;
            end
            if (alloc_i) begin
                entries_q[tailPtr_q].pc     <= allocPc_i;
                entries_q[tailPtr_q].filled <= 1'b0;
                entries_q[tailPtr_q].killed <= allocKilled_i;
                tailPtr_q <= tailPtr_q + 1'b1;
            end
            if (pop_i) begin
                headPtr_q <= headPtr_q + 1'b1;
            end
            count_q   <= count_q + CW'(alloc_i) - CW'(pop_i);
            pending_q <= pending_q + CW'(alloc_i) - CW'(fillHit);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt fetches, and
// presents {pc, inst, valid} from the fetch buffer to the IF/ID register.
// Build option DELAY_SLOT_EN: a taken branch spares the next instruction
// (MIPS delay slot) instead of squashing everything in flight.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [CW-1:0]   bufCount;
    logic            bufFull;
    logic            rstOn;
    logic            grant;
    logic            pop;
    logic            allocKilled;
    logic            keepHead;
    logic            presentOk;
    logic            headReady;
    logic            headKilled;
    logic [XLEN-1:0] headPc;
    logic [XLEN-1:0] headInst;

    assign rstOn   = (rst == RST_ACTIVE);
    assign bufFull = (bufCount == CW'(DEPTH));

    // Full is judged on registered occupancy, so a same-cycle pop does not reopen req
    assign imem_req  = !rstOn && !bufFull;
    assign imem_addr = fpc_q;
    assign grant     = imem_req && imem_gnt;

    assign if_valid = !rstOn && headReady && !headKilled && presentOk;
    assign if_pc    = if_valid ? headPc : '0;
    assign if_inst  = if_valid ? headInst : NOP_INST;

    // Killed heads that have their word are dropped without being presented
    assign pop = (if_valid && !stall) || (headReady && headKilled);

`ifdef DELAY_SLOT_EN
    logic            bufEmpty;
    logic            dsPend_q, dsPend_d;
    logic [XLEN-1:0] dsTarget_q, dsTarget_d;

    assign bufEmpty    = (bufCount == '0);
    assign keepHead    = 1'b1;
    assign presentOk   = 1'b1;
    assign allocKilled = br_taken && !bufEmpty;

    // Next fetch PC: with an empty buffer the branch waits for one more grant
    // (the delay slot) before jumping; otherwise the head is the delay slot
    always_comb begin
        fpc_d      = fpc_q;
        dsPend_d   = dsPend_q;
        dsTarget_d = dsTarget_q;
        if (grant) begin
            fpc_d = nextPc(fpc_q);
        end
        if (br_taken) begin
            if (bufEmpty && !grant) begin
                dsPend_d   = 1'b1;
                dsTarget_d = br_target;
            end else begin
                fpc_d    = br_target;
                dsPend_d = 1'b0;
            end
        end else if (dsPend_q && grant) begin
            fpc_d    = dsTarget_q;
            dsPend_d = 1'b0;
        end
    end

    // Pending delay-slot redirect state
    always_ff @(posedge clk) begin
        if (rstOn) begin
            dsPend_q   <= 1'b0;
            dsTarget_q <= '0;
        end else begin
            dsPend_q   <= dsPend_d;
            dsTarget_q <= dsTarget_d;
        end
    end
`else
    assign keepHead    = 1'b0;
    assign presentOk   = !br_taken;
    assign allocKilled = br_taken;

    // Next fetch PC: a redirect wins over sequential advance
    always_comb begin
        fpc_d = fpc_q;
        if (br_taken) begin
            fpc_d = br_target;
        end else if (grant) begin
            fpc_d = nextPc(fpc_q);
        end
    end
`endif

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (rstOn) begin
            fpc_q <= RESET_PC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (grant),
        .allocPc_i     (fpc_q),
        .allocKilled_i (allocKilled),
        .fill_i        (imem_rvalid),
        .fillData_i    (imem_rdata),
        .pop_i         (pop),
        .kill_i        (br_taken),
        .keepHead_i    (keepHead),
        .count_o       (bufCount),
        .headReady_o   (headReady),
        .headKilled_o  (headKilled),
        .headPc_o      (headPc),
        .headInst_o    (headInst)
    );

endmodule
